// File: rtl/retire_trace_buf.sv
// Retirement trace buffer: captures retired instructions from WB into a tagged FIFO
// and streams them to the difftest host, with back-pressure or drop-on-full.
module retire_trace_buf #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned SKID       = 2,
  parameter int unsigned STALL_MODE = 1,
  parameter int unsigned SEQ_W      = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       commit_valid_i,
  input  logic [XLEN-1:0]            commit_pc_i,
  input  logic [4:0]                 commit_rd_i,
  input  logic [XLEN-1:0]            commit_data_i,
  input  logic                       commit_wen_i,
  input  logic                       clear_i,
  output logic                       stall_o,
  output logic                       trace_valid_o,
  input  logic                       trace_ready_i,
  output logic [XLEN-1:0]            trace_pc_o,
  output logic [4:0]                 trace_rd_o,
  output logic [XLEN-1:0]            trace_data_o,
  output logic                       trace_wen_o,
  output logic [SEQ_W-1:0]           trace_seq_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [15:0]                drop_cnt_o,
  output logic                       overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] STALL_THR = PW'(DEPTH - SKID);

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [4:0]       rd;
    logic [XLEN-1:0]  data;
    logic             wen;
    logic [SEQ_W-1:0] seq;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            wr_entry;
  entry_t            head;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     level;
  logic [PW-1:0]     level_nxt;
  logic [SEQ_W-1:0]  seq_cnt;
  logic [15:0]       drop_cnt;
  logic              overflow;
  logic              stall;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;

  // Pointer state: the extra MSB is the wrap bit that separates full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level = wr_ptr - rd_ptr;

  assign pop  = !empty && trace_ready_i;
  assign push = commit_valid_i && !clear_i && (!full || pop);
  assign drop = commit_valid_i && !clear_i && full && !pop;

  assign wr_entry = '{pc: commit_pc_i, rd: commit_rd_i, data: commit_data_i,
                      wen: commit_wen_i, seq: seq_cnt};

  // Occupancy after this cycle's update; feeds the registered stall decision.
  always_comb begin
    level_nxt = level;
    if (clear_i) begin
      level_nxt = '0;
    end else if (push && !pop) begin
      level_nxt = level + PW'(1);
    end else if (pop && !push) begin
      level_nxt = level - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      seq_cnt  <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
      stall    <= 1'b0;
    end else begin
      if (clear_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      // Dropped commits still consume a tag so the host can see the gap.
      if (commit_valid_i && !clear_i) seq_cnt <= seq_cnt + SEQ_W'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
      stall <= (STALL_MODE != 0) && (level_nxt >= STALL_THR);
    end
  end

  // Payload storage has no reset; the head is masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (resetn && push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  always_comb begin
    head = '0;
    if (!empty) head = mem[rd_ptr[AW-1:0]];
  end

  assign trace_valid_o = !empty;
  assign trace_pc_o    = head.pc;
  assign trace_rd_o    = head.rd;
  assign trace_data_o  = head.data;
  assign trace_wen_o   = head.wen;
  assign trace_seq_o   = head.seq;
  assign level_o       = level;
  assign drop_cnt_o    = drop_cnt;
  assign overflow_o    = overflow;
  assign stall_o       = stall;

endmodule

// File: tb/tb_retire_trace_buf.sv
// Directed bench for retire_trace_buf: a vector table for the main flows plus
// hand-written sequences for full/clear/reset corners; second instance uses drop mode.
module tb_retire_trace_buf;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cv;
  logic [31:0] cpc;
  logic [4:0]  crd;
  logic [31:0] cdata;
  logic        cwen;
  logic        clr;
  logic        rdy;

  logic        stall, tvalid, twen, ovf;
  logic [31:0] tpc, tdata;
  logic [4:0]  trd;
  logic [7:0]  tseq;
  logic [3:0]  level;
  logic [15:0] drop_cnt;

  logic        stall0, tvalid0, twen0, ovf0;
  logic [31:0] tpc0, tdata0;
  logic [4:0]  trd0;
  logic [7:0]  tseq0;
  logic [3:0]  level0;
  logic [15:0] drop_cnt0;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] got[$];

  always #5 clk = ~clk;

  retire_trace_buf #(.XLEN(32), .DEPTH(8), .SKID(2), .STALL_MODE(1), .SEQ_W(8)) u_dut (
    .clk(clk), .resetn(resetn), .commit_valid_i(cv), .commit_pc_i(cpc), .commit_rd_i(crd),
    .commit_data_i(cdata), .commit_wen_i(cwen), .clear_i(clr), .stall_o(stall),
    .trace_valid_o(tvalid), .trace_ready_i(rdy), .trace_pc_o(tpc), .trace_rd_o(trd),
    .trace_data_o(tdata), .trace_wen_o(twen), .trace_seq_o(tseq), .level_o(level),
    .drop_cnt_o(drop_cnt), .overflow_o(ovf)
  );

  retire_trace_buf #(.XLEN(32), .DEPTH(8), .SKID(2), .STALL_MODE(0), .SEQ_W(8)) u_dut0 (
    .clk(clk), .resetn(resetn), .commit_valid_i(cv), .commit_pc_i(cpc), .commit_rd_i(crd),
    .commit_data_i(cdata), .commit_wen_i(cwen), .clear_i(clr), .stall_o(stall0),
    .trace_valid_o(tvalid0), .trace_ready_i(rdy), .trace_pc_o(tpc0), .trace_rd_o(trd0),
    .trace_data_o(tdata0), .trace_wen_o(twen0), .trace_seq_o(tseq0), .level_o(level0),
    .drop_cnt_o(drop_cnt0), .overflow_o(ovf0)
  );

  typedef struct {
    logic        rstn, cv, clr, rdy;
    logic [31:0] pc, data;
    logic [4:0]  rd;
    logic        wen;
    logic        e_valid;
    logic [7:0]  e_seq;
    logic [31:0] e_pc, e_data;
    logic [4:0]  e_rd;
    logic        e_wen;
    logic [3:0]  e_level;
    logic        e_stall;
    logic [15:0] e_drop;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rstn_v, cv_v, clr_v, rdy_v,
                              input logic [31:0] pc_v, input logic [4:0] rd_v,
                              input logic [31:0] data_v, input logic wen_v,
                              input logic ev, input logic [7:0] es,
                              input logic [31:0] epc, input logic [4:0] erd,
                              input logic [31:0] edata, input logic ewen,
                              input logic [3:0] elev, input logic est,
                              input logic [15:0] edr, input logic eov);
    vec_t v;
    v.rstn = rstn_v; v.cv = cv_v; v.clr = clr_v; v.rdy = rdy_v;
    v.pc = pc_v; v.rd = rd_v; v.data = data_v; v.wen = wen_v;
    v.e_valid = ev; v.e_seq = es; v.e_pc = epc; v.e_rd = erd; v.e_data = edata;
    v.e_wen = ewen; v.e_level = elev; v.e_stall = est; v.e_drop = edr; v.e_ovf = eov;
    return v;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic step(input logic rstn_v, cv_v, clr_v, rdy_v, input logic [31:0] pc_v,
                      input logic [4:0] rd_v, input logic [31:0] data_v, input logic wen_v);
    @(negedge clk);
    resetn = rstn_v; cv = cv_v; clr = clr_v; rdy = rdy_v;
    cpc = pc_v; crd = rd_v; cdata = data_v; cwen = wen_v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic commit(input logic rdy_v, input logic [31:0] pc_v);
    step(1'b1, 1'b1, 1'b0, rdy_v, pc_v, pc_v[6:2], ~pc_v, pc_v[2]);
  endtask

  // Pops until the selected instance is empty, recording head tags in order.
  task automatic drain(input bit sel);
    bit done = 1'b0;
    got.delete();
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      resetn = 1'b1; cv = 1'b0; clr = 1'b0; rdy = 1'b1;
      if ((sel ? tvalid0 : tvalid) !== 1'b1) begin
        done = 1'b1;
      end else begin
        got.push_back(sel ? tseq0 : tseq);
        @(posedge clk);
        #1;
      end
    end
    rdy = 1'b0;
    chk("drain budget", 32'(done), 32'd1);
  endtask

  task automatic chk_drain(input string nm, input logic [7:0] exp[$]);
    chk($sformatf("%s count", nm), 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s seq[%0d]", nm, i), 32'(got[i]), 32'(exp[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_q[$];
    bit seen_stall;
    resetn = 1'b0; cv = 1'b0; clr = 1'b0; rdy = 1'b0;
    cpc = '0; crd = '0; cdata = '0; cwen = 1'b0;

    // Reset, single commit with ready, then a fill to full with one drop.
    tbl.push_back(mk(0,0,0,0, 32'h0,5'd0,32'h0,0,  0,8'd0,32'h0,5'd0,32'h0,0, 4'd0,0,16'd0,0));
    tbl.push_back(mk(1,1,0,1, 32'h8000_0000,5'd5,32'h1234,1,
                     1,8'd0,32'h8000_0000,5'd5,32'h1234,1, 4'd1,0,16'd0,0));
    tbl.push_back(mk(1,0,0,1, 32'h0,5'd0,32'h0,0,  0,8'd0,32'h0,5'd0,32'h0,0, 4'd0,0,16'd0,0));
    tbl.push_back(mk(0,0,0,0, 32'h0,5'd0,32'h0,0,  0,8'd0,32'h0,5'd0,32'h0,0, 4'd0,0,16'd0,0));
    for (int k = 0; k <= 8; k++) begin
      tbl.push_back(mk(1,1,0,0, 32'h100 + 32'(4*k), 5'(k+1), 32'hA0 + 32'(k), ((k % 2) == 0),
                       1,8'd0,32'h100,5'd1,32'hA0,1,
                       (k >= 7) ? 4'd8 : 4'(k+1), (k >= 5), (k == 8) ? 16'd1 : 16'd0, (k == 8)));
    end
    tbl.push_back(mk(1,1,0,1, 32'h124,5'd10,32'hA9,0,
                     1,8'd1,32'h104,5'd2,32'hA1,0, 4'd8,1,16'd1,1));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rstn, tbl[i].cv, tbl[i].clr, tbl[i].rdy,
           tbl[i].pc, tbl[i].rd, tbl[i].data, tbl[i].wen);
      chk($sformatf("row%0d valid", i), 32'(tvalid), 32'(tbl[i].e_valid));
      chk($sformatf("row%0d level", i), 32'(level), 32'(tbl[i].e_level));
      chk($sformatf("row%0d stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("row%0d drop", i), 32'(drop_cnt), 32'(tbl[i].e_drop));
      chk($sformatf("row%0d ovf", i), 32'(ovf), 32'(tbl[i].e_ovf));
      if (tbl[i].e_valid) begin
        chk($sformatf("row%0d seq", i), 32'(tseq), 32'(tbl[i].e_seq));
        chk($sformatf("row%0d pc", i), tpc, tbl[i].e_pc);
        chk($sformatf("row%0d rd", i), 32'(trd), 32'(tbl[i].e_rd));
        chk($sformatf("row%0d data", i), tdata, tbl[i].e_data);
        chk($sformatf("row%0d wen", i), 32'(twen), 32'(tbl[i].e_wen));
      end
    end
    drain(1'b0);
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd9};
    chk_drain("gap drain", exp_q);

    // Full buffer with simultaneous push and pop: accepted, no drop.
    do_reset();
    for (int k = 0; k < 8; k++) commit(1'b0, 32'h200 + 32'(4*k));
    chk("full level", 32'(level), 32'd8);
    chk("full head seq", 32'(tseq), 32'd0);
    commit(1'b1, 32'h220);
    chk("pushpop level", 32'(level), 32'd8);
    chk("pushpop drop", 32'(drop_cnt), 32'd0);
    chk("pushpop head seq", 32'(tseq), 32'd1);
    drain(1'b0);
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    chk_drain("pushpop drain", exp_q);

    // Drop mode: 20 commits into a stalled host.
    do_reset();
    seen_stall = 1'b0;
    for (int k = 0; k < 20; k++) begin
      commit(1'b0, 32'h1000 + 32'(4*k));
      if (stall0 !== 1'b0) seen_stall = 1'b1;
    end
    chk("m0 stall", 32'(seen_stall), 32'd0);
    chk("m0 drop", 32'(drop_cnt0), 32'd12);
    chk("m0 level", 32'(level0), 32'd8);
    chk("m0 ovf", 32'(ovf0), 32'd1);
    drain(1'b1);
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    chk_drain("m0 drain", exp_q);

    // Clear with a same-cycle commit.
    do_reset();
    for (int k = 0; k < 3; k++) commit(1'b0, 32'h300 + 32'(4*k));
    chk("pre-clear level", 32'(level), 32'd3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h3F0, 5'd7, 32'h77, 1'b1);
    chk("clear level", 32'(level), 32'd0);
    chk("clear valid", 32'(tvalid), 32'd0);
    chk("clear drop", 32'(drop_cnt), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 5'd9, 32'hBEEF, 1'b0);
    chk("post-clear seq", 32'(tseq), 32'd3);
    chk("post-clear pc", tpc, 32'h400);
    chk("post-clear level", 32'(level), 32'd1);

    // Reset mid-stream with 5 queued entries and 4 drops.
    do_reset();
    for (int k = 0; k < 12; k++) commit(1'b0, 32'h500 + 32'(4*k));
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 5'd0, 32'h0, 1'b0);
    chk("pre-rst level", 32'(level), 32'd5);
    chk("pre-rst drop", 32'(drop_cnt), 32'd4);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h600, 5'd3, 32'h66, 1'b1);
    chk("rst valid", 32'(tvalid), 32'd0);
    chk("rst level", 32'(level), 32'd0);
    chk("rst drop", 32'(drop_cnt), 32'd0);
    chk("rst ovf", 32'(ovf), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h700, 5'd4, 32'h70, 1'b1);
    chk("post-rst valid", 32'(tvalid), 32'd1);
    chk("post-rst seq", 32'(tseq), 32'd0);
    chk("post-rst pc", tpc, 32'h700);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
